// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store unit between the core datapath and a valid/ready
// data-memory bus. Aligns byte/halfword/word stores onto bus lanes, extracts
// and sign/zero-extends load data, and stalls the core while the bus is busy.
// Misaligned or unsupported accesses raise memFault without any bus cycle.
//
// Optional feature: define LSU_TIMEOUT_EN to abort a bus access that has not
// been accepted after TIMEOUT cycles (reported with a busErr pulse in DONE).
// Without the macro the bus may wait indefinitely and busErr is tied low.

module lsu_mem_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] dataAdr,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        stall,
  output logic        memFault,
  output logic        busErr,
  output logic        busValid,
  input  logic        busReady,
  output logic        busWe,
  output logic [31:0] busAdr,
  output logic [3:0]  busWstrb,
  output logic [31:0] busWdata,
  input  logic [31:0] busRdata
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUS,
    ST_DONE
  } state_t;

  state_t state_q, state_d;

  logic [31:0] bus_adr_q, bus_adr_d;
  logic        bus_we_q, bus_we_d;
  logic [3:0]  bus_wstrb_q, bus_wstrb_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  adr_lo_q, adr_lo_d;
  logic [31:0] rd_reg_q, rd_reg_d;

  logic        req;
  logic        illegal;
  logic        misaligned;
  logic        accept;
  logic        expire;
  logic        err_now;
  logic [3:0]  st_wstrb;
  logic [31:0] st_wdata;
  logic [31:0] lane_word;
  logic [31:0] load_ext;

  // A TIMEOUT below one would make the abort fire before the bus can answer.
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("lsu_mem_ctrl: TIMEOUT must be at least 1");
  end

  // Classify the current core request: legality, alignment and fault flag.
  always_comb begin
    req        = memRead | memWrite;
    illegal    = 1'b0;
    misaligned = 1'b0;
    if (memWrite) begin
      case (funct3)
        3'b000, 3'b001, 3'b010: illegal = 1'b0;
        default:                illegal = 1'b1;
      endcase
    end else begin
      case (funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: illegal = 1'b0;
        default:                                illegal = 1'b1;
      endcase
    end
    case (funct3[1:0])
      2'b01:   misaligned = dataAdr[0];
      2'b10:   misaligned = |dataAdr[1:0];
      default: misaligned = 1'b0;
    endcase
    memFault = req & (illegal | misaligned);
    accept   = (state_q == ST_IDLE) & req & ~memFault;
  end

  // Place store data onto the byte lanes selected by the low address bits.
  always_comb begin
    st_wstrb = 4'b0000;
    st_wdata = writeData;
    case (funct3[1:0])
      2'b00: begin
        st_wstrb = 4'b0001 << dataAdr[1:0];
        st_wdata = {4{writeData[7:0]}};
      end
      2'b01: begin
        st_wstrb = 4'b0011 << dataAdr[1:0];
        st_wdata = {2{writeData[15:0]}};
      end
      default: begin
        st_wstrb = 4'b1111;
        st_wdata = writeData;
      end
    endcase
    if (!memWrite) begin
      st_wstrb = 4'b0000;
    end
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timed_out_q, timed_out_d;

  // Count unanswered bus cycles; remember whether the access was aborted.
  always_comb begin
    cnt_d       = cnt_q;
    timed_out_d = timed_out_q;
    expire      = (state_q == ST_BUS) & ~busReady & (cnt_q == CNT_LAST);
    case (state_q)
      ST_IDLE: begin
        cnt_d       = '0;
        timed_out_d = 1'b0;
      end
      ST_BUS: begin
        if (!busReady) begin
          cnt_d = cnt_q + 1'b1;
        end
        timed_out_d = expire;
      end
      default: begin
        cnt_d       = cnt_q;
        timed_out_d = timed_out_q;
      end
    endcase
    err_now = (state_q == ST_DONE) & timed_out_q;
  end

  // Timeout counter and abort flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      timed_out_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      timed_out_q <= timed_out_d;
    end
  end
`else
  // Without the timeout option the bus access is never aborted.
  always_comb begin
    expire  = 1'b0;
    err_now = 1'b0;
  end
`endif

  // FSM next-state: accept in IDLE, wait for the bus, present result once.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_BUS;
        end
      end
      ST_BUS: begin
        if (busReady || expire) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Capture the bus request when accepted and the read data on completion.
  always_comb begin
    bus_adr_d   = bus_adr_q;
    bus_we_d    = bus_we_q;
    bus_wstrb_d = bus_wstrb_q;
    bus_wdata_d = bus_wdata_q;
    funct3_d    = funct3_q;
    adr_lo_d    = adr_lo_q;
    rd_reg_d    = rd_reg_q;
    if (accept) begin
      bus_adr_d   = {dataAdr[31:2], 2'b00};
      bus_we_d    = memWrite;
      bus_wstrb_d = st_wstrb;
      bus_wdata_d = st_wdata;
      funct3_d    = funct3;
      adr_lo_d    = dataAdr[1:0];
    end
    if ((state_q == ST_BUS) && busReady) begin
      rd_reg_d = busRdata;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bus_adr_q   <= '0;
      bus_we_q    <= 1'b0;
      bus_wstrb_q <= '0;
      bus_wdata_q <= '0;
      funct3_q    <= '0;
      adr_lo_q    <= '0;
      rd_reg_q    <= '0;
    end else begin
      state_q     <= state_d;
      bus_adr_q   <= bus_adr_d;
      bus_we_q    <= bus_we_d;
      bus_wstrb_q <= bus_wstrb_d;
      bus_wdata_q <= bus_wdata_d;
      funct3_q    <= funct3_d;
      adr_lo_q    <= adr_lo_d;
      rd_reg_q    <= rd_reg_d;
    end
  end

  // Extract and extend the addressed byte/halfword from the captured word.
  always_comb begin
    lane_word = rd_reg_q >> {adr_lo_q, 3'b000};
    case (funct3_q[1:0])
      2'b00:   load_ext = {{24{~funct3_q[2] & lane_word[7]}}, lane_word[7:0]};
      2'b01:   load_ext = {{16{~funct3_q[2] & lane_word[15]}}, lane_word[15:0]};
      default: load_ext = lane_word;
    endcase
  end

  // FSM outputs: bus handshake, core stall, result and error reporting.
  always_comb begin
    busValid = (state_q == ST_BUS);
    stall    = accept | (state_q == ST_BUS);
    busErr   = err_now;
    readData = '0;
    if ((state_q == ST_DONE) && !err_now) begin
      readData = load_ext;
    end
  end

  assign busAdr   = bus_adr_q;
  assign busWe    = bus_we_q;
  assign busWstrb = bus_wstrb_q;
  assign busWdata = bus_wdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed test-plan accesses followed
// by randomized loads/stores, compared against a byte-level reference model.

module tb_lsu_mem_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        memRead;
  logic        memWrite;
  logic [2:0]  funct3;
  logic [31:0] dataAdr;
  logic [31:0] writeData;
  logic [31:0] readData;
  logic        stall;
  logic        memFault;
  logic        busErr;
  logic        busValid;
  logic        busReady;
  logic        busWe;
  logic [31:0] busAdr;
  logic [3:0]  busWstrb;
  logic [31:0] busWdata;
  logic [31:0] busRdata;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] lastRead;

  lsu_mem_ctrl #(.TIMEOUT(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .memRead  (memRead),
    .memWrite (memWrite),
    .funct3   (funct3),
    .dataAdr  (dataAdr),
    .writeData(writeData),
    .readData (readData),
    .stall    (stall),
    .memFault (memFault),
    .busErr   (busErr),
    .busValid (busValid),
    .busReady (busReady),
    .busWe    (busWe),
    .busAdr   (busAdr),
    .busWstrb (busWstrb),
    .busWdata (busWdata),
    .busRdata (busRdata)
  );

  always #5 clk = ~clk;

  // Hard stop in case something escapes every bounded wait.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---- reference model: the access viewed as a run of bytes ----
  function automatic int accessBytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit isFault(input bit isStore, input logic [2:0] f3, input logic [31:0] adr);
    bit legal;
    if (isStore) legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    else legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                 (f3 == 3'b100) || (f3 == 3'b101);
    if (!legal) return 1'b1;
    return (int'(adr[1:0]) % accessBytes(f3)) != 0;
  endfunction

  function automatic logic [3:0] expStrobe(input bit isStore, input logic [2:0] f3, input logic [31:0] adr);
    logic [3:0] s = 4'b0000;
    if (isStore)
      for (int i = 0; i < accessBytes(f3); i++) s[int'(adr[1:0]) + i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] expWdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] w;
    int n = accessBytes(f3);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] expRead(input logic [2:0] f3, input logic [31:0] adr, input logic [31:0] rd);
    logic [31:0] v = 32'h0;
    int n = accessBytes(f3);
    int lo = int'(adr[1:0]);
    for (int i = 0; i < n; i++) v[8*i +: 8] = rd[8*(lo + i) +: 8];
    if (!f3[2] && n < 4 && v[8*n-1])
      for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
    return v;
  endfunction

  // Run one core access (called at a negedge, returns at a negedge in IDLE).
  task automatic applyStimulus(input string tag, input bit isStore, input logic [2:0] f3,
                               input logic [31:0] adr, input logic [31:0] wd,
                               input logic [31:0] rd, input int waits);
    bit fault = isFault(isStore, f3, adr);
    int stallCycles = 1;
    int waitLeft = waits;
    int budget = 0;
    memRead   = !isStore;
    memWrite  = isStore;
    funct3    = f3;
    dataAdr   = adr;
    writeData = wd;
    busReady  = 1'($urandom_range(0, 1));
    busRdata  = $urandom();
    #1;
    checkOutput({tag, ".memFault"}, 32'(memFault), 32'(fault));
    checkOutput({tag, ".stall0"}, 32'(stall), 32'(!fault));
    checkOutput({tag, ".valid0"}, 32'(busValid), 32'd0);
    if (fault) begin
      @(negedge clk);
      checkOutput({tag, ".faultValid"}, 32'(busValid), 32'd0);
      checkOutput({tag, ".faultStall"}, 32'(stall), 32'd0);
      return;
    end
    @(negedge clk);
    while (stall === 1'b1 && budget < 64) begin
      checkOutput({tag, ".valid"}, 32'(busValid), 32'd1);
      checkOutput({tag, ".adr"}, busAdr, {adr[31:2], 2'b00});
      checkOutput({tag, ".we"}, 32'(busWe), 32'(isStore));
      checkOutput({tag, ".wstrb"}, 32'(busWstrb), 32'(expStrobe(isStore, f3, adr)));
      if (isStore) checkOutput({tag, ".wdata"}, busWdata, expWdata(f3, wd));
      if (waitLeft > 0) begin
        busReady = 1'b0;
        busRdata = $urandom();
        waitLeft--;
      end else begin
        busReady = 1'b1;
        busRdata = rd;
      end
      stallCycles++;
      budget++;
      @(negedge clk);
    end
    checkOutput({tag, ".stallLen"}, 32'(stallCycles), 32'(2 + waits));
    checkOutput({tag, ".doneStall"}, 32'(stall), 32'd0);
    checkOutput({tag, ".doneValid"}, 32'(busValid), 32'd0);
    checkOutput({tag, ".busErr"}, 32'(busErr), 32'd0);
    lastRead = readData;
    if (!isStore) checkOutput({tag, ".readData"}, readData, expRead(f3, adr, rd));
    if (budget >= 64) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end
    busReady = 1'($urandom_range(0, 1));
    busRdata = $urandom();
    @(negedge clk);
    checkOutput({tag, ".idleRead"}, readData, 32'd0);
  endtask

  task automatic goIdle(input int n);
    memRead  = 1'b0;
    memWrite = 1'b0;
    busReady = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    memRead = 1'b0; memWrite = 1'b0; funct3 = 3'b000;
    dataAdr = 32'h0; writeData = 32'h0; busReady = 1'b0; busRdata = 32'h0;
    repeat (2) @(negedge clk);
    checkOutput("reset.valid", 32'(busValid), 32'd0);
    checkOutput("reset.we", 32'(busWe), 32'd0);
    checkOutput("reset.wstrb", 32'(busWstrb), 32'd0);
    checkOutput("reset.adr", busAdr, 32'd0);
    checkOutput("reset.wdata", busWdata, 32'd0);
    checkOutput("reset.readData", readData, 32'd0);
    checkOutput("reset.busErr", 32'(busErr), 32'd0);
    checkOutput("reset.stall", 32'(stall), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed test-plan accesses.
    applyStimulus("SW", 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0);
    applyStimulus("LB", 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_FF00, 0);
    checkOutput("LB.const", lastRead, 32'hFFFF_FF80);
    applyStimulus("LBU", 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_FF00, 0);
    checkOutput("LBU.const", lastRead, 32'h0000_0080);
    applyStimulus("SH", 1'b1, 3'b001, 32'h102, 32'h0000_1234, 32'h0, 3);
    applyStimulus("LWmis", 1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0);
    applyStimulus("LHmis", 1'b0, 3'b001, 32'h103, 32'h0, 32'h0, 0);
    applyStimulus("L011", 1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0);
    applyStimulus("SBU", 1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 0);
    applyStimulus("LHU", 1'b0, 3'b101, 32'h102, 32'h0, 32'h8001_7FFF, 2);
    checkOutput("LHU.const", lastRead, 32'h0000_8001);
    goIdle(1);

    // Reset during BUS abandons the transaction.
    memRead = 1'b1; funct3 = 3'b010; dataAdr = 32'h200; busReady = 1'b0;
    @(negedge clk);
    checkOutput("rstBus.valid", 32'(busValid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstBus.validAfter", 32'(busValid), 32'd0);
    checkOutput("rstBus.adr", busAdr, 32'd0);
    checkOutput("rstBus.readData", readData, 32'd0);
    rst = 1'b0;
    memRead = 1'b0;
    @(negedge clk);
    checkOutput("rstBus.idleStall", 32'(stall), 32'd0);
    applyStimulus("LWafterRst", 1'b0, 3'b010, 32'h204, 32'h0, 32'h1357_9BDF, 1);
    goIdle(1);

`ifdef LSU_TIMEOUT_EN
    // Unanswered access is aborted after TO bus cycles.
    memRead = 1'b1; funct3 = 3'b010; dataAdr = 32'h300; busReady = 1'b0;
    @(negedge clk);
    for (int i = 0; i < TO; i++) begin
      checkOutput("tmo.valid", 32'(busValid), 32'd1);
      @(negedge clk);
    end
    checkOutput("tmo.validDrop", 32'(busValid), 32'd0);
    checkOutput("tmo.busErr", 32'(busErr), 32'd1);
    checkOutput("tmo.readData", readData, 32'd0);
    checkOutput("tmo.stall", 32'(stall), 32'd0);
    @(negedge clk);
    checkOutput("tmo.busErrPulse", 32'(busErr), 32'd0);
    goIdle(1);
`else
    // Without the timeout option an unanswered access keeps stalling.
    memRead = 1'b1; funct3 = 3'b010; dataAdr = 32'h300; busReady = 1'b0;
    repeat (40) @(negedge clk);
    checkOutput("noTmo.stall", 32'(stall), 32'd1);
    checkOutput("noTmo.valid", 32'(busValid), 32'd1);
    checkOutput("noTmo.busErr", 32'(busErr), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    goIdle(1);
`endif

    // Randomized back-to-back accesses, some illegal or misaligned.
    for (int k = 0; k < 80; k++) begin
      bit st = 1'($urandom_range(0, 1));
      logic [2:0] f3 = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7))
                                                  : 3'($urandom_range(0, 2)) | (st ? 3'b000 : 3'($urandom_range(0, 1)) << 2);
      applyStimulus($sformatf("rnd%0d", k), st, f3, $urandom(), $urandom(), $urandom(),
                    int'($urandom_range(0, 3)));
    end
    goIdle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
# lsu_mem_ctrl

Load/store unit between the core datapath and the data-memory bus. Takes the ALU-computed data address, store data and access size from the core, performs byte/halfword/word alignment, and runs a valid/ready bus transaction. It stalls the core until the access completes and returns sign- or zero-extended load data on `readData`. Misaligned and unsupported accesses are flagged without touching the bus.

## Interface
Parameters:
- `TIMEOUT`, 16: bus cycles allowed before abort. Used only with `LSU_TIMEOUT_EN`; must be ≥ 1.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `memRead` in 1: core load request, held stable while `stall` = 1.
- `memWrite` in 1: core store request, held stable while `stall` = 1. Must not be high together with `memRead`.
- `funct3` in 3: access size/sign. 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `dataAdr` in 32: byte address.
- `writeData` in 32: store data, right-aligned.
- `readData` out 32: extended load data. Valid in the DONE state, 0 otherwise.
- `stall` out 1: core must hold its PC and request.
- `memFault` out 1: misaligned or unsupported access (combinational, same cycle).
- `busErr` out 1: one-cycle pulse in DONE when the access timed out.
- `busValid` out 1: bus request.
- `busReady` in 1: bus accept/complete.
- `busWe` out 1: write enable.
- `busAdr` out 32: word address, `{dataAdr[31:2],2'b00}`.
- `busWstrb` out 4: byte strobes.
- `busWdata` out 32: lane-shifted store data.
- `busRdata` in 32: read data, sampled when `busValid & busReady`.

## Operation
- `req = memRead | memWrite`.
- Legal accesses:
  - Loads: funct3 ∈ {000,001,010,100,101}.
  - Stores: funct3 ∈ {000,001,010}.
- Alignment rules: H requires `dataAdr[0]`=0; W requires `dataAdr[1:0]`=00.
- `memFault = req & (illegal | misaligned)`. A faulting access does not stall and issues no bus cycle.
- FSM states:
  - IDLE: if `req & ~memFault`, register busAdr/busWe/busWstrb/busWdata and go to BUS.
  - BUS: `busValid`=1. On `busReady`, capture `busRdata` into `rdReg` and go to DONE.
  - DONE: load result presented. Always return to IDLE.
- Strobes:
  - SB: `4'b0001 << adr[1:0]`.
  - SH: `4'b0011 << adr[1:0]`.
  - SW: `4'b1111`.
  - Loads: 0.
- `busWdata`:
  - SB: byte replicated ×4.
  - SH: halfword replicated ×2.
  - SW: as is.
- Load extraction from `rdReg`: byte/halfword selected by `adr[1:0]`. Sign-extended for B/H, zero-extended for BU/HU. `funct3`/`adr` used for extraction are the copies registered in IDLE.
- `busAdr`, `busWe`, `busWstrb` and `busWdata` are stable while `busValid` = 1. `busValid` never drops before `busReady`, except on reset or timeout.

## Timing
- Reset values: state IDLE, `busValid` 0, `busWe` 0, `busWstrb` 0, `busAdr` 0, `busWdata` 0, `rdReg` 0, `readData` 0, `busErr` 0.
- `stall = (IDLE & req & ~memFault) | BUS`. It is low in DONE, so the core retires the access at the end of the DONE cycle.
- Zero-wait-state access (`busReady` high in the first BUS cycle):
  - cycle 0 IDLE, stall=1.
  - cycle 1 BUS, stall=1.
  - cycle 2 DONE, stall=0, readData valid.
  - Total 3 cycles. Each wait state adds 1 cycle.
- Back-to-back: after DONE, the next instruction's request is seen in IDLE on the following cycle. There is no overlap.
- Reset asserted in BUS: state goes to IDLE and `busValid` goes to 0 on that edge. The transaction is abandoned.
- `busReady` while `busValid`=0 is ignored.

## Configuration
- `LSU_TIMEOUT_EN` defined:
  - A counter is cleared on entry to BUS and increments each BUS cycle without `busReady`.
  - When the count reaches `TIMEOUT`, drop `busValid` and go to DONE with `busErr`=1 and `readData`=0.
  - `busReady` in the same cycle as expiry wins: normal completion.
- Not defined: no counter, BUS waits indefinitely, `busErr` tied 0.

## Test plan
- SW adr 0x100, data 0xDEADBEEF, ready immediate → busAdr 0x100, wstrb 1111, wdata 0xDEADBEEF, stall high for 2 cycles, DONE on cycle 2.
- LB adr 0x103, busRdata 0x80FF_FF00 → readData 0xFFFF_FF80. Same access as LBU → 0x0000_0080.
- SH adr 0x102, data 0x0000_1234, 3 wait states → wstrb 1100, wdata 0x1234_1234, stall high for 5 cycles, busValid/busAdr stable throughout.
- LW adr 0x101, then LH adr 0x103 → memFault=1, stall=0, busValid never asserted. Unsupported load funct3 011 is also faulted.
- Reset pulsed during BUS with busReady low → busValid 0 next cycle, state IDLE, a new LW then completes normally.
- `LSU_TIMEOUT_EN`, TIMEOUT=4, busReady held low → busValid drops after 4 BUS cycles, busErr pulses 1 cycle, readData 0. Without the macro the same stimulus stalls forever.
